// File: rtl/core_pkg.sv
// Shared core definitions: fetch state encoding, PC width and special instruction words.
package core_pkg;

   localparam int          PC_W       = 32;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

endpackage : core_pkg

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and holds one
// fetched instruction for decode behind a valid/ready handshake.
// Fetch stops on the halt word; redirects override everything and restart fetch.
module instruction_fetch #(
   parameter int                ADDR_W     = 5,
   parameter int                PC_W       = core_pkg::PC_W,
   parameter logic [PC_W-1:0]   RESET_PC   = '0,
   parameter logic [31:0]       HALT_INSTR = core_pkg::HALT_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_instr,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [PC_W-1:0]   out_pc,
   output logic              halted
);

   import core_pkg::*;

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [PC_W-1:0]   out_pc_q, out_pc_d;
   logic              load_s;
   logic              handshake_s;
   logic              unused_redirect_lsb_s;

   // Redirect targets are word-aligned silently, so the two low bits are dropped.
   assign unused_redirect_lsb_s = ^redirect_pc[1:0];

   assign rom_addr    = pc_q[ADDR_W+1:2];
   assign handshake_s = out_valid_q & out_ready;
   assign load_s      = (state_q == RUN) & (~out_valid_q | out_ready);

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;
   assign halted    = (state_q == HALT);

   // Next-state logic: redirect first, then fetch, then drain of a pending output.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;

      if (redirect_valid) begin
         // Any ROM word this cycle is discarded; a concurrent handshake still counts.
         pc_d        = {redirect_pc[PC_W-1:2], 2'b00};
         out_valid_d = 1'b0;
         state_d     = RUN;
      end else if (load_s) begin
         if (rom_instr == HALT_INSTR) begin
            // Halt word is not forwarded and the PC parks on its address.
            out_valid_d = 1'b0;
            state_d     = HALT;
         end else begin
            out_valid_d = 1'b1;
            out_instr_d = rom_instr;
            out_pc_d    = pc_q;
            pc_d        = pc_q + PC_W'(32'd4);
         end
      end else begin
         case (state_q)
            HALT: begin
               // No fetch while halted; the last instruction still drains.
               if (handshake_s) begin
                  out_valid_d = 1'b0;
               end else begin
                  out_valid_d = out_valid_q;
               end
            end
            RUN: begin
               out_valid_d = out_valid_q;
            end
            default: begin
               state_d     = RUN;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State, PC and output register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'h0000_0000;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

endmodule : instruction_fetch
